odo_sbox_prog: RTL and testbench
================================

Name: odo_sbox_prog

Overview:
- Programmable, double-buffered WIDTH-bit S-box for the Odo mining datapath.
- Serves LANES lookups per cycle, forward or inverse, from the active bank.
- Software or the epoch-seed generator loads the next permutation into the shadow bank while lookups continue.
- Bijectivity is checked during load; only a valid permutation is committed, by an atomic bank swap.

Parameters:
- WIDTH, 6: symbol width in bits; table depth is 2^WIDTH.
- LANES, 4: parallel lookup lanes sharing one table.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ld_start  in  1  pulse; begin (or restart) filling the shadow bank.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat accepted when ld_valid && ld_ready.
- ld_data  in  WIDTH  table entry for the next sequential address.
- ld_ok  out  1  one-cycle pulse: shadow committed, banks swapped.
- ld_err  out  1  one-cycle pulse: duplicate detected, shadow discarded.
- tbl_valid  out  1  active bank holds a committed permutation.
- in_valid  in  1  lookup request.
- in_inv  in  1  0 = forward S(x), 1 = inverse S^-1(x); applies to all lanes.
- in_ready  out  1  equals tbl_valid.
- in_data  in  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  result valid.
- out_data  out  LANES*WIDTH  lookup results, same lane packing.

Behaviour:
- Storage: two banks, each holding a forward table F[2^WIDTH] and an inverse table R[2^WIDTH]. bank_sel selects the active bank. Table contents are not reset.
- Reset values: tbl_valid=0, bank_sel=0, ld_ready=0, ld_ok=0, ld_err=0, out_valid=0, out_data=0, FSM=IDLE, load counter=0, seen bitmap=0, dup flag=0.
- FSM states:
  - IDLE: ld_ready=0; ld_valid ignored. ld_start -> FILL.
  - FILL: ld_ready=1. Each accepted beat with counter a and data d:
    - shadow F[a]=d; shadow R[d]=a.
    - if seen[d] already set, dup=1; then set seen[d].
    - a increments. The beat with a=2^WIDTH-1 moves to COMMIT.
  - COMMIT (one cycle): ld_ready=0.
    - dup=0: toggle bank_sel, set tbl_valid=1, pulse ld_ok.
    - dup=1: pulse ld_err; bank_sel and tbl_valid unchanged.
    - Then -> IDLE.
- Entering FILL, from IDLE or via ld_start while already in FILL, clears counter, seen bitmap and dup. A restart discards the partial load. A beat presented in the same cycle as ld_start is dropped.
- ld_start during COMMIT is ignored.
- Lookup:
  - Accepted when in_valid && tbl_valid. One-cycle latency: next cycle out_valid=1 and out_data[k] = (in_inv ? R : F)[in_data[k]] of the active bank.
  - A cycle with no accepted request drives out_valid=0; out_data holds its last value.
  - No backpressure on the output.
- Swap boundary: a lookup accepted in the COMMIT cycle uses the old bank. Lookups from the following cycle use the new bank. Lookups are never stalled by loading.
- in_valid while tbl_valid=0: dropped, out_valid stays 0.
- Asynchronous reset mid-load or mid-lookup: all state returns to reset values immediately. tbl_valid=0 after reset even though bank contents persist.
- Width rules: counter is WIDTH+1 bits wide internally or uses a terminal compare, so it never wraps. Addresses are unsigned.

Test Plan:
- Reset, then lookup with in_valid=1 -> in_ready=0, out_valid stays 0, tbl_valid=0.
- Load F[i]=(5i+3) mod 64 (WIDTH=6), 64 beats, then lookups:
  - ld_ok pulses exactly once, 64 cycles after the first beat; tbl_valid=1.
  - Forward lookup on lanes {0x01,0x00,0x3F,0x0C} -> {0x08,0x03,0x3E,0x3F}.
  - Inverse lookup of 0x08 -> 0x01.
- Load a table with entries 5 and 9 both =0x2A while streaming lookups -> ld_err pulses, no ld_ok, and lookups keep returning the previous (5i+3) results.
- Load identity while issuing a lookup every cycle -> the request accepted in the COMMIT cycle returns the old table value, and the next request returns the identity.
- Start a load, send 20 beats, assert ld_start again, then send 64 identity beats -> ld_ok pulses, and lookup of 0x13 returns 0x13 with no residue from the first partial load.
- Assert rst_n=0 at beat 30 of a load -> all outputs reach reset values asynchronously. After release, ld_valid is ignored until ld_start, and tbl_valid=0.

Source files
------------

// File: rtl/odo_sbox_prog_if.sv
// Bundle for the odo_sbox_prog load and lookup channels.
// Handshake: a load beat moves on a rising clk edge where ld_valid && ld_ready are both high;
// a lookup moves on an edge where in_valid && in_ready are both high. Results have no ready.
interface odo_sbox_prog_if #(
  parameter int WIDTH = 6,
  parameter int LANES = 4
);
  logic                   ld_start;
  logic                   ld_valid;
  logic                   ld_ready;
  logic [WIDTH-1:0]       ld_data;
  logic                   ld_ok;
  logic                   ld_err;
  logic                   tbl_valid;
  logic                   in_valid;
  logic                   in_inv;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic [LANES*WIDTH-1:0] out_data;

  modport master (
    output ld_start, ld_valid, ld_data, in_valid, in_inv, in_data,
    input  ld_ready, ld_ok, ld_err, tbl_valid, in_ready, out_valid, out_data
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, in_valid, in_inv, in_data,
    output ld_ready, ld_ok, ld_err, tbl_valid, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/odo_sbox_prog.sv
// Double-buffered programmable S-box: LANES forward/inverse lookups per cycle from the active
// bank while the shadow bank is filled, bijectivity-checked, and committed by a bank swap.
module odo_sbox_prog #(
  parameter int WIDTH = 6,
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  odo_sbox_prog_if.slave      bus,
  output logic [1:0]          dbg_state
);
  localparam int DEPTH = 1 << WIDTH;
  localparam logic [WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   ld_ready_c;
  logic                   beat;
  logic                   start_fill;
  logic                   bank_sel;
  logic                   shadow;
  logic                   tbl_valid_q;
  logic                   ld_ok_q;
  logic                   ld_err_q;
  logic                   dup_q;
  logic [WIDTH-1:0]       cnt_q;
  logic [DEPTH-1:0]       seen_q;
  logic                   out_valid_q;
  logic [LANES*WIDTH-1:0] out_data_q;
  logic [LANES*WIDTH-1:0] lut;
  logic                   lookup;

  logic [WIDTH-1:0] f_tbl [2][DEPTH];
  logic [WIDTH-1:0] r_tbl [2][DEPTH];

  assign shadow     = ~bank_sel;
  assign beat       = ld_ready_c && bus.ld_valid;
  assign start_fill = bus.ld_start && (state_q != COMMIT);
  assign lookup     = bus.in_valid && tbl_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ld_ready drops in a restart cycle so the coincident beat is visibly refused.
  always_comb begin
    state_d    = state_q;
    ld_ready_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ld_start) state_d = FILL;
      end
      FILL: begin
        ld_ready_c = !bus.ld_start;
        if (!bus.ld_start && bus.ld_valid && cnt_q == LAST) state_d = COMMIT;
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      seen_q      <= '0;
      dup_q       <= 1'b0;
      bank_sel    <= 1'b0;
      tbl_valid_q <= 1'b0;
      ld_ok_q     <= 1'b0;
      ld_err_q    <= 1'b0;
    end else begin
      ld_ok_q  <= 1'b0;
      ld_err_q <= 1'b0;
      if (start_fill) begin
        cnt_q  <= '0;
        seen_q <= '0;
        dup_q  <= 1'b0;
      end else if (beat) begin
        cnt_q               <= cnt_q + 1'b1;
        seen_q[bus.ld_data] <= 1'b1;
        if (seen_q[bus.ld_data]) dup_q <= 1'b1;
      end
      if (state_q == COMMIT) begin
        if (dup_q) begin
          ld_err_q <= 1'b1;
        end else begin
          bank_sel    <= ~bank_sel;
          tbl_valid_q <= 1'b1;
          ld_ok_q     <= 1'b1;
        end
      end
    end
  end

  // Table RAMs carry no reset; tbl_valid gates their use after power-up.
  always_ff @(posedge clk) begin
    if (beat) begin
      f_tbl[shadow][cnt_q]       <= bus.ld_data;
      r_tbl[shadow][bus.ld_data] <= cnt_q;
    end
  end

  always_comb begin
    lut = '0;
    for (int k = 0; k < LANES; k++) begin
      lut[k*WIDTH +: WIDTH] = bus.in_inv ? r_tbl[bank_sel][bus.in_data[k*WIDTH +: WIDTH]]
                                         : f_tbl[bank_sel][bus.in_data[k*WIDTH +: WIDTH]];
    end
  end

  // bank_sel only flips at the end of COMMIT, so a lookup taken in that cycle reads the old bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= lookup;
      if (lookup) out_data_q <= lut;
    end
  end

  assign bus.ld_ready  = ld_ready_c;
  assign bus.ld_ok     = ld_ok_q;
  assign bus.ld_err    = ld_err_q;
  assign bus.tbl_valid = tbl_valid_q;
  assign bus.in_ready  = tbl_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_odo_sbox_prog.sv
// Self-checking bench for odo_sbox_prog: vector table, hand sequences for load corners,
// and a scoreboard comparing random lookups against a permutation-level reference model.
module tb_odo_sbox_prog;
  localparam int W  = 6;
  localparam int L  = 4;
  localparam int N  = 64;
  localparam int DW = W * L;

  typedef logic [DW-1:0] word_t;
  typedef struct {
    bit    inv;
    word_t din;
    word_t dout;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  odo_sbox_prog_if #(.WIDTH(W), .LANES(L)) bus ();

  odo_sbox_prog #(.WIDTH(W), .LANES(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: the committed permutation as a plain array
  logic [W-1:0] m_tbl  [N];
  logic [W-1:0] ld_buf [N];
  bit           m_tbl_valid = 1'b0;
  word_t        m_last_out  = '0;
  logic [DW-1:0] exp_q[$];
  bit           exp_pend = 1'b0;
  int           ok_cnt = 0;
  int           err_cnt = 0;
  int           ok_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic word_t model_lookup(input bit inv, input word_t din);
    word_t r;
    r = '0;
    for (int k = 0; k < L; k++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = din[k*W +: W];
      y = '0;
      if (!inv) y = m_tbl[x];
      else for (int j = 0; j < N; j++) if (m_tbl[j] == x) y = j[W-1:0];
      r[k*W +: W] = y;
    end
    return r;
  endfunction

  // scoreboard: predict at the accepting edge, compare one cycle later on the falling edge
  always @(posedge clk) begin
    if (rst_n && bus.in_valid && m_tbl_valid) begin
      exp_q.push_back(model_lookup(bus.in_inv, bus.in_data));
      exp_pend <= 1'b1;
    end else begin
      exp_pend <= 1'b0;
    end
  end

  always @(negedge clk) begin
    word_t e;
    if (!rst_n) begin
      exp_q.delete();
      m_last_out = '0;
    end else if (exp_pend) begin
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("lookup_valid", 64'(bus.out_valid), 64'd1);
      chk("lookup_data", 64'(bus.out_data), 64'(e));
      m_last_out = e;
    end else begin
      chk("idle_valid", 64'(bus.out_valid), 64'd0);
      chk("hold_data", 64'(bus.out_data), 64'(m_last_out));
    end
    if (bus.ld_ok) begin
      ok_cnt++;
      ok_cyc = cyc;
    end
    if (bus.ld_err) err_cnt++;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input int restart_at);
    bit seen [N];
    bit perm;
    int ok0, err0, first;
    perm = 1'b1;
    first = 0;
    ok0 = ok_cnt;
    err0 = err_cnt;
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (seen[ld_buf[i]]) perm = 1'b0;
      seen[ld_buf[i]] = 1'b1;
    end
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b0;
    step();
    bus.ld_start = 1'b0;
    if (restart_at >= 0) begin
      for (int i = 0; i < restart_at; i++) begin
        bus.ld_valid = 1'b1;
        bus.ld_data  = '0;
        step();
      end
      bus.ld_start = 1'b1;
      bus.ld_valid = 1'b1;
      bus.ld_data  = '0;
      step();
      bus.ld_start = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = ld_buf[i];
      step();
      if (i == 0) first = cyc;
    end
    bus.ld_valid = 1'b0;
    step();
    // the commit edge has just passed: from here on lookups see the new table
    if (perm) begin
      m_tbl = ld_buf;
      m_tbl_valid = 1'b1;
    end
    repeat (2) step();
    chk("ld_ok_count", 64'(ok_cnt - ok0), perm ? 64'd1 : 64'd0);
    chk("ld_err_count", 64'(err_cnt - err0), perm ? 64'd0 : 64'd1);
    if (perm) chk("ld_ok_latency", 64'(ok_cyc - first), 64'd64);
    chk("tbl_valid_after_load", 64'(bus.tbl_valid), 64'(m_tbl_valid));
    chk("idle_after_load", 64'(dbg_state), 64'd0);
  endtask

  task automatic stream_lookups(input int n, input bit dense);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.in_inv   = 1'($urandom_range(0, 1));
      bus.in_data  = DW'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic lookup1(input bit inv, input word_t din, output word_t q);
    bus.in_valid = 1'b1;
    bus.in_inv   = inv;
    bus.in_data  = din;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    q = bus.out_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  vec_t         vecs [6];
  word_t        q;
  int           j;
  logic [W-1:0] tmp;

  initial begin
    // vectors against F[i] = (5i+3) mod 64; lane 0 is the rightmost field
    vecs[0] = '{1'b0, {6'h0C, 6'h3F, 6'h00, 6'h01}, {6'h3F, 6'h3E, 6'h03, 6'h08}};
    vecs[1] = '{1'b1, {6'h3F, 6'h3E, 6'h03, 6'h08}, {6'h0C, 6'h3F, 6'h00, 6'h01}};
    vecs[2] = '{1'b0, {6'h20, 6'h10, 6'h04, 6'h02}, {6'h23, 6'h13, 6'h17, 6'h0D}};
    vecs[3] = '{1'b1, {6'h23, 6'h13, 6'h17, 6'h0D}, {6'h20, 6'h10, 6'h04, 6'h02}};
    vecs[4] = '{1'b1, {6'h08, 6'h08, 6'h08, 6'h08}, {6'h01, 6'h01, 6'h01, 6'h01}};
    vecs[5] = '{1'b0, {6'h3F, 6'h3F, 6'h00, 6'h00}, {6'h3E, 6'h3E, 6'h03, 6'h03}};

    rst_n        = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_inv   = 1'b0;
    bus.in_data  = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // reset state and lookup refused with no table
    chk("rst_tbl_valid", 64'(bus.tbl_valid), 64'd0);
    chk("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
    chk("rst_ld_ok", 64'(bus.ld_ok), 64'd0);
    chk("rst_ld_err", 64'(bus.ld_err), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = vecs[0].din;
    #1;
    chk("no_tbl_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("no_tbl_out_valid", 64'(bus.out_valid), 64'd0);

    // affine table (5i+3) and vector table
    for (int i = 0; i < N; i++) ld_buf[i] = W'((5 * i + 3) % 64);
    bus.ld_start = 1'b1;
    #1;
    chk("ld_ready_idle", 64'(bus.ld_ready), 64'd0);
    bus.ld_start = 1'b0;
    load_table(-1);
    chk("in_ready_loaded", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      lookup1(vecs[i].inv, vecs[i].din, q);
      chk($sformatf("vec%0d", i), 64'(q), 64'(vecs[i].dout));
    end

    // duplicate entries 5 and 9 while lookups stream: rejected, old table stays live
    ld_buf[5] = 6'h2A;
    ld_buf[9] = 6'h2A;
    fork
      load_table(-1);
      stream_lookups(75, 1'b0);
    join
    lookup1(vecs[0].inv, vecs[0].din, q);
    chk("after_dup_fwd", 64'(q), 64'(vecs[0].dout));

    // identity with a lookup every cycle across the commit boundary
    for (int i = 0; i < N; i++) ld_buf[i] = W'(i);
    fork
      load_table(-1);
      stream_lookups(75, 1'b1);
    join
    lookup1(1'b0, vecs[2].din, q);
    chk("identity_fwd", 64'(q), 64'(vecs[2].din));

    // random permutation
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = ld_buf[i];
      ld_buf[i] = ld_buf[j];
      ld_buf[j] = tmp;
    end
    fork
      load_table(-1);
      stream_lookups(80, 1'b0);
    join
    stream_lookups(40, 1'b0);

    // restart after 20 duplicate beats, then a full identity load
    for (int i = 0; i < N; i++) ld_buf[i] = W'(i);
    load_table(20);
    lookup1(1'b0, {4{6'h13}}, q);
    chk("restart_fwd_13", 64'(q), 64'({4{6'h13}}));
    lookup1(1'b1, {6'h13, 6'h00, 6'h3F, 6'h13}, q);
    chk("restart_inv", 64'(q), 64'({6'h13, 6'h00, 6'h3F, 6'h13}));

    // asynchronous reset at beat 30 with a lookup in flight
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_inv   = 1'b0;
    bus.in_data  = vecs[0].din;
    for (int i = 0; i < 30; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = W'(i);
      step();
    end
    #2;
    rst_n = 1'b0;
    m_tbl_valid = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("async_tbl_valid", 64'(bus.tbl_valid), 64'd0);
    chk("async_in_ready", 64'(bus.in_ready), 64'd0);
    chk("async_ld_ready", 64'(bus.ld_ready), 64'd0);
    chk("async_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_out_data", 64'(bus.out_data), 64'd0);
    chk("async_state", 64'(dbg_state), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.ld_data = W'(i);
      #1;
      chk("post_rst_ld_ready", 64'(bus.ld_ready), 64'd0);
      step();
      chk("post_rst_state", 64'(dbg_state), 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.ld_valid = 1'b0;
    chk("post_rst_tbl_valid", 64'(bus.tbl_valid), 64'd0);

    // fresh load after reset works
    for (int i = 0; i < N; i++) ld_buf[i] = W'((5 * i + 3) % 64);
    fork
      load_table(-1);
      stream_lookups(70, 1'b0);
    join
    lookup1(vecs[1].inv, vecs[1].din, q);
    chk("post_rst_inv", 64'(q), 64'(vecs[1].dout));
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
